// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA exponentiation controller: register offsets,
// FSM state encoding and the byte-lane merge used by the register bank.
package rsa_pkg;

    localparam int RSA_WIDTH = 32;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_BASE   = 3'd2;
    localparam logic [2:0] REG_EXP    = 3'd3;
    localparam logic [2:0] REG_MOD    = 3'd4;
    localparam logic [2:0] REG_RESULT = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        REDUCE,
        LOOP,
        MUL,
        SQR,
        FIN
    } state_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  lanes);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/rsa_mod_mul.sv
// Bit-serial modular multiplier: p = a*x mod m, scanning x MSB-first.
// The first bit is folded into the start cycle so done lands WIDTH cycles later.
module rsa_mod_mul
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] m,
    output logic             done,
    output logic [WIDTH-1:0] p
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH+1:0] acc;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] m_q;
    logic [CW-1:0]    cnt;
    logic             running;

    // acc < m and a < m keep 2*acc + a below 3m, so two conditional subtractions suffice
    function automatic logic [WIDTH+1:0] step(input logic [WIDTH+1:0] acc_in,
                                              input logic             bit_in,
                                              input logic [WIDTH-1:0] a_in,
                                              input logic [WIDTH-1:0] m_in);
        logic [WIDTH+1:0] t;
        logic [WIDTH+1:0] mw;
        mw = {2'b00, m_in};
        t  = {acc_in[WIDTH:0], 1'b0} + (bit_in ? {2'b00, a_in} : '0);
        if (t >= mw) t = t - mw;
        if (t >= mw) t = t - mw;
        return t;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            a_q     <= '0;
            x_q     <= '0;
            m_q     <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            a_q     <= a;
            m_q     <= m;
            x_q     <= x << 1;
            acc     <= step('0, x[WIDTH-1], a, m);
            cnt     <= CW'(WIDTH - 1);
            running <= 1'b1;
        end else if (running) begin
            if (cnt != '0) begin
                acc <= step(acc, x_q[WIDTH-1], a_q, m_q);
                x_q <= x_q << 1;
                cnt <= cnt - 1'b1;
            end else begin
                running <= 1'b0;
            end
        end
    end

    assign done = running && (cnt == '0);
    assign p    = acc[WIDTH-1:0];

endmodule

// File: rtl/rsa_ctrl.sv
// Memory-mapped RSA controller: register bank, one-cycle ack handshake and the
// right-to-left square-and-multiply FSM driving one shared modular multiplier.
module rsa_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rsa_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  we,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        busy
);

    state_t state, state_nxt;

    logic [WIDTH-1:0] base_q, exp_q, mod_q, result_q;
    logic [WIDTH-1:0] e_q, r_q, b_q;
    logic             done_q, err_q;
    logic             mm_active, mm_start, mm_done;
    logic [WIDTH-1:0] mm_a, mm_x, mm_p;
    logic [31:0]      read_val;
    logic [2:0]       sel;
    logic             is_write, stall, accept;
    logic             start_req, start_ok, start_trivial;
    logic             unused_addr_bits;

    assign sel              = addr[4:2];
    assign unused_addr_bits = ^{addr[31:5], addr[1:0]};
    assign is_write         = (we != 4'b0000);
    assign busy             = (state != IDLE);

    // A RESULT read during a run parks the core until FIN, where r is forwarded
    assign stall         = (sel == REG_RESULT) && !is_write && busy && (state != FIN);
    assign accept        = rsa_en && !ack && !stall;
    assign start_req     = accept && is_write && (sel == REG_CTRL) && wdata[0] && (state == IDLE);
    assign start_ok      = start_req && (mod_q >= WIDTH'(2));
    assign start_trivial = start_req && (mod_q < WIDTH'(2));

    always_comb begin
        state_nxt = state;
        mm_start  = 1'b0;
        mm_a      = '0;
        mm_x      = '0;
        case (state)
            IDLE:   if (start_ok) state_nxt = REDUCE;
            REDUCE: begin
                mm_start = !mm_active;
                mm_a     = WIDTH'(1);
                mm_x     = base_q;
                if (mm_done) state_nxt = LOOP;
            end
            LOOP: begin
                if (e_q == '0)  state_nxt = FIN;
                else if (e_q[0]) state_nxt = MUL;
                else             state_nxt = SQR;
            end
            MUL: begin
                mm_start = !mm_active;
                mm_a     = r_q;
                mm_x     = b_q;
                if (mm_done) state_nxt = SQR;
            end
            SQR: begin
                mm_start = !mm_active;
                mm_a     = b_q;
                mm_x     = b_q;
                if (mm_done) state_nxt = LOOP;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        read_val = '0;
        case (sel)
            REG_STATUS: read_val = {29'b0, err_q, done_q, busy};
            REG_BASE:   read_val = 32'(base_q);
            REG_EXP:    read_val = 32'(exp_q);
            REG_MOD:    read_val = 32'(mod_q);
            REG_RESULT: read_val = (state == FIN) ? 32'(r_q) : 32'(result_q);
            default:    read_val = '0;
        endcase
    end

    rsa_mod_mul #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mm_start),
        .a     (mm_a),
        .x     (mm_x),
        .m     (mod_q),
        .done  (mm_done),
        .p     (mm_p)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mm_active <= 1'b0;
            base_q    <= '0;
            exp_q     <= '0;
            mod_q     <= '0;
            result_q  <= '0;
            e_q       <= '0;
            r_q       <= '0;
            b_q       <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (mm_start)     mm_active <= 1'b1;
            else if (mm_done) mm_active <= 1'b0;
            if (start_ok) begin
                e_q    <= exp_q;
                r_q    <= WIDTH'(1);
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end
            if (start_trivial) begin
                result_q <= '0;
                done_q   <= 1'b1;
                err_q    <= (mod_q == '0);
            end
            if (mm_done) begin
                case (state)
                    REDUCE:  b_q <= mm_p;
                    MUL:     r_q <= mm_p;
                    SQR: begin
                        b_q <= mm_p;
                        e_q <= e_q >> 1;
                    end
                    default: ;
                endcase
            end
            if (state == FIN) begin
                result_q <= r_q;
                done_q   <= 1'b1;
            end
            // Operand registers are frozen while a run is using them
            if (accept && is_write && !busy) begin
                case (sel)
                    REG_BASE: base_q <= WIDTH'(merge_bytes(32'(base_q), wdata, we));
                    REG_EXP:  exp_q  <= WIDTH'(merge_bytes(32'(exp_q), wdata, we));
                    REG_MOD:  mod_q  <= WIDTH'(merge_bytes(32'(mod_q), wdata, we));
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack   <= 1'b0;
            rdata <= '0;
        end else begin
            ack   <= accept;
            rdata <= accept ? read_val : '0;
        end
    end

endmodule

// File: tb/tb_rsa_ctrl.sv
// Scoreboard bench for rsa_ctrl: a driver issues bus accesses and queues the
// expected read data; a monitor pops and compares on every ack.
module tb_rsa_ctrl;

    localparam int W = 32;
    localparam logic [2:0] A_CTRL = 3'd0, A_STATUS = 3'd1, A_BASE = 3'd2,
                           A_EXP = 3'd3, A_MOD = 3'd4, A_RESULT = 3'd5;

    logic        clk = 1'b0;
    logic        rst;
    logic        rsa_en;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  we;
    logic        ack, busy;

    always #5 clk = ~clk;

    rsa_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .rsa_en (rsa_en),
        .addr   (addr),
        .wdata  (wdata),
        .we     (we),
        .rdata  (rdata),
        .ack    (ack),
        .busy   (busy)
    );

    typedef struct {
        logic [31:0] val;
        logic [31:0] mask;
        bit          chk;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   len_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [31:0] m_base, m_exp, m_mod, m_result;
    logic        m_done, m_err;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic finishBench();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_val, input logic [31:0] new_val,
                                          input logic [3:0] lanes);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) if (lanes[i]) res[8*i +: 8] = new_val[8*i +: 8];
        return res;
    endfunction

    function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e,
                                           input logic [31:0] m);
        longint unsigned r, bb, ee, mm;
        if (m < 2) return 32'd0;
        mm = 64'(m);
        r  = 1;
        bb = 64'(b) % mm;
        ee = 64'(e);
        while (ee != 0) begin
            if (ee[0]) r = (r * bb) % mm;
            bb = (bb * bb) % mm;
            ee = ee >> 1;
        end
        return 32'(r);
    endfunction

    // Busy cycles: reduce step, per exponent bit a loop visit plus a square,
    // a multiply per set bit, and the final loop visit plus FIN.
    function automatic int op_cycles(input logic [31:0] e);
        int len = 0;
        int pop = 0;
        for (int i = 0; i < 32; i++) if (e[i]) begin len = i + 1; pop++; end
        return (W + 1) + len * (W + 2) + pop * (W + 1) + 2;
    endfunction

    exp_t mon_e;
    logic prev_ack = 1'b0;
    int   busy_run = 0;

    always @(negedge clk) begin
        if (ack) begin
            checkOutput("ack_width", {31'b0, prev_ack}, 32'd0);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_ack: got ack with nothing outstanding");
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.chk) checkOutput(mon_e.name, rdata & mon_e.mask, mon_e.val & mon_e.mask);
            end
        end else if (prev_ack) begin
            checkOutput("rdata_after_ack", rdata, 32'd0);
        end
        prev_ack <= ack;
        if (rst) busy_run <= 0;
        else if (busy) busy_run <= busy_run + 1;
        else if (busy_run > 0) begin
            if (len_q.size() > 0) checkOutput("busy_cycles", 32'(busy_run), 32'(len_q.pop_front()));
            busy_run <= 0;
        end
    end

    task automatic applyStimulus(input logic [2:0] idx, input logic [3:0] lanes,
                                 input logic [31:0] wd, input logic [31:0] expv,
                                 input bit chk, input string name,
                                 output int ack_cyc, output logic [31:0] rd);
        exp_t e;
        logic [31:0] junk;
        e.val  = expv;
        e.mask = 32'hFFFF_FFFF;
        e.chk  = chk;
        e.name = name;
        sb_q.push_back(e);
        junk   = $urandom();
        rsa_en = 1'b1;
        addr   = (junk & 32'hFFFF_FFE3) | {27'b0, idx, 2'b00};
        we     = lanes;
        wdata  = wd;
        ack_cyc = 0;
        rd      = '0;
        for (int n = 0; n < 5000; n++) begin
            @(negedge clk);
            if (ack) begin
                ack_cyc = cyc;
                rd      = rdata;
                return;
            end
        end
        checks++;
        errors++;
        $display("[TB] FAIL ack_timeout %s: got no ack, expected one within 5000 cycles", name);
        finishBench();
    endtask

    task automatic idleBus();
        rsa_en = 1'b0;
        we     = 4'b0000;
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] v, input logic [3:0] lanes);
        int c;
        logic [31:0] d;
        applyStimulus(idx, lanes, v, 32'd0, 1'b0, "write", c, d);
        idleBus();
    endtask

    task automatic rdChk(input logic [2:0] idx, input logic [31:0] expv, input string name);
        int c;
        logic [31:0] d;
        applyStimulus(idx, 4'b0000, 32'd0, expv, 1'b1, name, c, d);
        idleBus();
    endtask

    task automatic setReg(input logic [2:0] idx, input logic [31:0] v, input logic [3:0] lanes);
        wr(idx, v, lanes);
        case (idx)
            A_BASE:  m_base = merge(m_base, v, lanes);
            A_EXP:   m_exp  = merge(m_exp, v, lanes);
            A_MOD:   m_mod  = merge(m_mod, v, lanes);
            default: ;
        endcase
    endtask

    task automatic startOp(input bit track_len, output int t_ack);
        logic [31:0] d;
        if (m_mod >= 2) begin
            if (track_len) len_q.push_back(op_cycles(m_exp));
            m_result = modexp(m_base, m_exp, m_mod);
            m_err    = 1'b0;
        end else begin
            m_result = 32'd0;
            m_err    = (m_mod == 0);
        end
        m_done = 1'b1;
        applyStimulus(A_CTRL, 4'hF, 32'd1, 32'd0, 1'b0, "start", t_ack, d);
        idleBus();
        checkOutput("busy_after_start", {31'b0, busy}, {31'b0, (m_mod >= 2)});
    endtask

    task automatic waitDone();
        int c;
        logic [31:0] d;
        for (int n = 0; n < 4000; n++) begin
            applyStimulus(A_STATUS, 4'b0000, 32'd0, 32'(busy ? 32'd1 : 32'd2), 1'b0, "poll", c, d);
            idleBus();
            checkOutput("poll_err", {31'b0, d[2]}, 32'd0);
            if (d[1]) begin
                rdChk(A_STATUS, {29'b0, m_err, m_done, 1'b0}, "status_done");
                rdChk(A_RESULT, m_result, "result");
                return;
            end
        end
        checks++;
        errors++;
        $display("[TB] FAIL done_timeout: got done=0 after 4000 polls, expected done=1");
        finishBench();
    endtask

    task automatic runOp(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m);
        int t;
        setReg(A_BASE, b, 4'hF);
        setReg(A_EXP, e, 4'hF);
        setReg(A_MOD, m, 4'hF);
        startOp(1'b1, t);
        waitDone();
    endtask

    task automatic zeroModel();
        m_base = '0; m_exp = '0; m_mod = '0; m_result = '0;
        m_done = 1'b0; m_err = 1'b0;
    endtask

    initial begin
        #(1_000_000);
        checks++;
        errors++;
        $display("[TB] FAIL watchdog: got no completion, expected bench to finish");
        finishBench();
    end

    initial begin
        int t0, t1, t2;
        logic [31:0] d, v0, v1, v2;
        logic [3:0]  l0, l1, l2;

        rst = 1'b1; rsa_en = 1'b0; addr = '0; wdata = '0; we = '0;
        zeroModel();
        repeat (3) @(negedge clk);
        checkOutput("reset_ack", {31'b0, ack}, 32'd0);
        checkOutput("reset_rdata", rdata, 32'd0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        $display("[TB] reset register reads");
        for (int i = 0; i < 8; i++) rdChk(3'(i), 32'd0, "reset_reg");

        $display("[TB] 4^13 mod 497 with writes and start while busy");
        setReg(A_BASE, 32'd4, 4'hF);
        setReg(A_EXP, 32'd13, 4'hF);
        setReg(A_MOD, 32'd497, 4'hF);
        startOp(1'b1, t0);
        wr(A_BASE, 32'd99, 4'hF);
        wr(A_CTRL, 32'd1, 4'hF);
        waitDone();
        rdChk(A_RESULT, 32'd445, "result_445");
        rdChk(A_BASE, 32'd4, "base_kept");

        $display("[TB] base above modulus and zero exponent");
        runOp(32'd100, 32'd3, 32'd7);
        setReg(A_EXP, 32'd0, 4'hF);
        setReg(A_MOD, 32'd13, 4'hF);
        startOp(1'b1, t0);
        waitDone();

        $display("[TB] degenerate moduli");
        setReg(A_MOD, 32'd1, 4'hF);
        startOp(1'b1, t0);
        rdChk(A_STATUS, 32'd2, "mod1_status");
        rdChk(A_RESULT, 32'd0, "mod1_result");
        setReg(A_MOD, 32'd0, 4'hF);
        startOp(1'b1, t0);
        rdChk(A_STATUS, 32'd6, "mod0_status");
        rdChk(A_RESULT, 32'd0, "mod0_result");

        $display("[TB] stalled RESULT read");
        setReg(A_BASE, 32'd4, 4'hF);
        setReg(A_EXP, 32'd13, 4'hF);
        setReg(A_MOD, 32'd497, 4'hF);
        startOp(1'b1, t0);
        applyStimulus(A_RESULT, 4'b0000, 32'd0, 32'd445, 1'b1, "stalled_result", t1, d);
        idleBus();
        checkOutput("stall_cycles", 32'(t1 - t0), 32'(op_cycles(32'd13)));
        rdChk(A_STATUS, 32'd2, "stall_status");

        $display("[TB] back-to-back stores");
        v0 = $urandom(); v1 = $urandom(); v2 = $urandom();
        l0 = 4'($urandom_range(1, 15)); l1 = 4'($urandom_range(1, 15)); l2 = 4'($urandom_range(1, 15));
        applyStimulus(A_BASE, l0, v0, 32'd0, 1'b0, "b2b", t0, d);
        applyStimulus(A_EXP, l1, v1, 32'd0, 1'b0, "b2b", t1, d);
        applyStimulus(A_MOD, l2, v2, 32'd0, 1'b0, "b2b", t2, d);
        idleBus();
        m_base = merge(m_base, v0, l0);
        m_exp  = merge(m_exp, v1, l1);
        m_mod  = merge(m_mod, v2, l2);
        checkOutput("b2b_gap1", 32'(t1 - t0), 32'd2);
        checkOutput("b2b_gap2", 32'(t2 - t1), 32'd2);
        rdChk(A_BASE, m_base, "b2b_base");
        rdChk(A_EXP, m_exp, "b2b_exp");
        rdChk(A_MOD, m_mod, "b2b_mod");

        $display("[TB] randomized operations");
        for (int k = 0; k < 5; k++) begin
            v0 = $urandom();
            v1 = $urandom() & 32'h0000_FFFF;
            v2 = $urandom();
            if (k == 0) v2 = v2 & 32'h0000_00FF;
            if (v2 < 2) v2 = v2 + 2;
            runOp(v0, v1, v2);
            v0 = $urandom();
            l0 = 4'($urandom_range(1, 15));
            setReg(A_BASE, v0, l0);
            rdChk(A_BASE, m_base, "lane_base");
        end

        $display("[TB] reset during a long run");
        setReg(A_BASE, 32'd4, 4'hF);
        setReg(A_EXP, 32'hFFFF_FFFF, 4'hF);
        setReg(A_MOD, 32'd497, 4'hF);
        startOp(1'b0, t0);
        repeat (80) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_ack", {31'b0, ack}, 32'd0);
        rst = 1'b0;
        zeroModel();
        @(negedge clk);
        for (int i = 1; i < 6; i++) rdChk(3'(i), 32'd0, "abort_reg");
        runOp(32'd4, 32'd13, 32'd497);

        repeat (4) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        finishBench();
    end

endmodule
